// File: rtl/key_sched_pkg.sv
// key_sched_pkg: scan codes, event codes, decoder states and output bit positions
package key_sched_pkg;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_RIGHT   = 8'h74;
  localparam logic [7:0] SC_UP      = 8'h75;
  localparam logic [7:0] SC_DOWN    = 8'h72;
  localparam logic [7:0] SC_PLAY    = 8'h4D;
  localparam logic [7:0] SC_RESTART = 8'h2D;

  typedef enum logic [2:0] {
    EV_LEFT    = 3'd0,
    EV_RIGHT   = 3'd1,
    EV_UP      = 3'd2,
    EV_DOWN    = 3'd3,
    EV_PLAY    = 3'd4,
    EV_RESTART = 3'd5,
    EV_NONE    = 3'd7
  } key_ev_e;

  typedef enum logic [1:0] {DEC_IDLE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_e;

  localparam int BLK_LEFT    = 0;
  localparam int BLK_RIGHT   = 1;
  localparam int BLK_DOWN    = 2;
  localparam int BLK_PLAY    = 3;
  localparam int BLK_RESTART = 4;
  localparam int SNK_LEFT    = 0;
  localparam int SNK_RIGHT   = 1;
  localparam int SNK_UP      = 2;
  localparam int SNK_DOWN    = 3;

  function automatic key_ev_e scan_to_ev(input logic ext, input logic [7:0] b);
    return ext ? (b == SC_LEFT  ? EV_LEFT  :
                  b == SC_RIGHT ? EV_RIGHT :
                  b == SC_UP    ? EV_UP    :
                  b == SC_DOWN  ? EV_DOWN  : EV_NONE)
               : (b == SC_PLAY    ? EV_PLAY    :
                  b == SC_RESTART ? EV_RESTART : EV_NONE);
  endfunction
endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: 4-entry x 3-bit event queue; a push while full is accepted only alongside a pop
module key_event_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic       full,
  output logic       empty,
  output logic [2:0] dout
);
  logic [2:0] mem_q [4];
  logic [2:0] mem_d [4];
  logic [1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wr, rd;

  assign full  = cnt_q == 3'd4;
  assign empty = cnt_q == 3'd0;
  assign dout  = mem_q[rp_q];
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = din;
    wp_d  = wp_q + 2'(wr);
    rp_d  = rp_q + 2'(rd);
    cnt_d = cnt_q + 3'(wr) - 3'(rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: PS/2 decoder, event FIFO and rate-limited key dispatcher; auto-repeat via KEY_REPEAT_EN
module key_event_scheduler
  import key_sched_pkg::*;
#(
  parameter int DISPATCH_GAP = 16,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_state,
  input  logic       game_sel,
  output logic [4:0] blk_key_press,
  output logic [3:0] snk_key_press,
  output logic       fifo_overflow
);
  localparam int GW = $clog2(DISPATCH_GAP + 1);

  dec_state_e st_q, st_d;
  key_ev_e    make_ev, rpt_ev, head_ev;
  logic       make_done, dec_push, rpt_push, push, pop, full, empty, fired;
  logic [2:0] head;
  logic [GW-1:0] gap_q, gap_d;
  logic [4:0] blk_q, blk_d;
  logic [3:0] snk_q, snk_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    st_d      = st_q;
    make_done = 1'b0;
    make_ev   = EV_NONE;
    if (ps2_state) begin
      st_d = DEC_IDLE;
      if (st_q == DEC_IDLE && ps2_byte == SC_EXT) st_d = DEC_EXT;
      else if (st_q == DEC_IDLE && ps2_byte == SC_BRK) st_d = DEC_BRK;
      else if (st_q == DEC_EXT && ps2_byte == SC_BRK) st_d = DEC_EXT_BRK;
      else if (st_q == DEC_IDLE || st_q == DEC_EXT) begin
        make_done = 1'b1;
        make_ev   = scan_to_ev(st_q == DEC_EXT, ps2_byte);
      end
    end
  end

  assign dec_push = make_done && make_ev != EV_NONE;

`ifdef KEY_REPEAT_EN
  logic    brk_done, held_q, held_d, phase_q, phase_d;
  key_ev_e brk_ev, held_ev_q, held_ev_d;
  logic [31:0] tmr_q, tmr_d;

  assign brk_done = ps2_state && (st_q == DEC_BRK || st_q == DEC_EXT_BRK);
  assign brk_ev   = scan_to_ev(st_q == DEC_EXT_BRK, ps2_byte);
  assign rpt_ev   = held_ev_q;

  // phase 0 waits the initial delay, phase 1 runs at the repeat rate
  always_comb begin
    held_d    = held_q;
    held_ev_d = held_ev_q;
    phase_d   = phase_q;
    tmr_d     = tmr_q;
    rpt_push  = 1'b0;
    if (make_done) begin
      held_d    = make_ev <= EV_DOWN;
      held_ev_d = make_ev;
      phase_d   = 1'b0;
      tmr_d     = '0;
    end else if (brk_done && held_q && brk_ev == held_ev_q) begin
      held_d = 1'b0;
      tmr_d  = '0;
    end else if (held_q) begin
      if (tmr_q == (phase_q ? 32'(REPEAT_RATE - 1) : 32'(REPEAT_DELAY - 1))) begin
        rpt_push = 1'b1;
        phase_d  = 1'b1;
        tmr_d    = '0;
      end else tmr_d = tmr_q + 32'd1;
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      held_q    <= 1'b0;
      held_ev_q <= EV_NONE;
      phase_q   <= 1'b0;
      tmr_q     <= '0;
    end else begin
      held_q    <= held_d;
      held_ev_q <= held_ev_d;
      phase_q   <= phase_d;
      tmr_q     <= tmr_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
  assign rpt_push   = 1'b0;
  assign rpt_ev     = EV_NONE;
`endif

  assign push    = dec_push || rpt_push;
  assign pop     = !empty && gap_q == '0;
  assign head_ev = key_ev_e'(head);

  key_event_fifo u_fifo (
    .clk  (CLK_50M),
    .rst_n(RST_N),
    .push (push),
    .pop  (pop),
    .din  (dec_push ? make_ev : rpt_ev),
    .full (full),
    .empty(empty),
    .dout (head)
  );

  // events with no target in the selected game are consumed silently
  always_comb begin
    blk_d = '0;
    snk_d = '0;
    if (pop) begin
      unique case (head_ev)
        EV_LEFT:    if (game_sel) snk_d[SNK_LEFT] = 1'b1;  else blk_d[BLK_LEFT] = 1'b1;
        EV_RIGHT:   if (game_sel) snk_d[SNK_RIGHT] = 1'b1; else blk_d[BLK_RIGHT] = 1'b1;
        EV_DOWN:    if (game_sel) snk_d[SNK_DOWN] = 1'b1;  else blk_d[BLK_DOWN] = 1'b1;
        EV_UP:      if (game_sel) snk_d[SNK_UP] = 1'b1;
        EV_PLAY:    if (!game_sel) blk_d[BLK_PLAY] = 1'b1;
        EV_RESTART: if (!game_sel) blk_d[BLK_RESTART] = 1'b1;
        default: ;
      endcase
    end
    fired = |{blk_d, snk_d};
    gap_d = fired ? GW'(DISPATCH_GAP - 1) : (gap_q != '0 ? gap_q - GW'(1) : gap_q);
    ovf_d = ovf_q || (push && full && !pop);
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      st_q  <= DEC_IDLE;
      gap_q <= '0;
      blk_q <= '0;
      snk_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      gap_q <= gap_d;
      blk_q <= blk_d;
      snk_q <= snk_d;
      ovf_q <= ovf_d;
    end
  end

  assign blk_key_press = blk_q;
  assign snk_key_press = snk_q;
  assign fifo_overflow = ovf_q;
endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: directed checks of decode, routing, pacing, overflow, reset and optional auto-repeat
module tb_key_event_scheduler;
  logic       CLK_50M = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       ps2_state = 1'b0;
  logic       game_sel = 1'b0;
  logic [4:0] blk_key_press;
  logic [3:0] snk_key_press;
  logic       fifo_overflow;
  int checks = 0;
  int errors = 0;

  key_event_scheduler #(.DISPATCH_GAP(16), .REPEAT_DELAY(100), .REPEAT_RATE(20)) dut (
    .CLK_50M      (CLK_50M),
    .RST_N        (RST_N),
    .ps2_byte     (ps2_byte),
    .ps2_state    (ps2_state),
    .game_sel     (game_sel),
    .blk_key_press(blk_key_press),
    .snk_key_press(snk_key_press),
    .fifo_overflow(fifo_overflow)
  );

  always #10 CLK_50M = ~CLK_50M;

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK_50M);
    ps2_byte  = b;
    ps2_state = 1'b1;
    @(negedge CLK_50M);
    ps2_state = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_50M);
  endtask

  task automatic do_reset;
    @(negedge CLK_50M);
    ps2_state = 1'b0;
    RST_N = 1'b0;
    idle(2);
    RST_N = 1'b1;
  endtask

  task automatic watch(input int n, output int cnt, output int min_sp, output bit multi);
    int last;
    cnt = 0; min_sp = 1000; multi = 0; last = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK_50M);
      if (blk_key_press != 0 || snk_key_press != 0) begin
        if ($countones({blk_key_press, snk_key_press}) > 1) multi = 1;
        if (cnt > 0 && i - last < min_sp) min_sp = i - last;
        last = i;
        cnt++;
      end
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    idle(2);
    checks++;
    if (blk_key_press !== 5'b0 || snk_key_press !== 4'b0 || fifo_overflow !== 1'b0)
      $display("FAIL reset: blk=%b snk=%b ovf=%b required all 0", blk_key_press, snk_key_press, fifo_overflow);
    if (blk_key_press !== 5'b0 || snk_key_press !== 4'b0 || fifo_overflow !== 1'b0) errors++;
    RST_N = 1'b1;
    idle(3);
    checks++;
    if (blk_key_press !== 5'b0 || snk_key_press !== 4'b0) begin
      errors++;
      $display("FAIL reset_release: blk=%b snk=%b required 0", blk_key_press, snk_key_press);
    end
  endtask

  task automatic test_mapping;
    bit       ext [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit [7:0] bt  [12] = '{8'h6B, 8'h74, 8'h72, 8'h4D, 8'h2D, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h75, 8'h4D, 8'h2D};
    bit       sel [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bit [4:0] eb  [12] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    bit [3:0] es  [12] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 12; i++) begin
      idle(20);
      game_sel = sel[i];
      if (ext[i]) send_byte(8'hE0);
      send_byte(bt[i]);
      checks++;
      if (blk_key_press !== 5'b0 || snk_key_press !== 4'b0) begin
        errors++;
        $display("FAIL map%0d_early: blk=%b snk=%b required 0", i, blk_key_press, snk_key_press);
      end
      @(negedge CLK_50M);
      checks++;
      if (blk_key_press !== eb[i] || snk_key_press !== es[i]) begin
        errors++;
        $display("FAIL map%0d_pulse: blk=%b snk=%b required blk=%b snk=%b", i, blk_key_press, snk_key_press, eb[i], es[i]);
      end
      @(negedge CLK_50M);
      checks++;
      if (blk_key_press !== 5'b0 || snk_key_press !== 4'b0) begin
        errors++;
        $display("FAIL map%0d_width: blk=%b snk=%b required 0", i, blk_key_press, snk_key_press);
      end
    end
  endtask

  task automatic test_sel_change;
    idle(20);
    game_sel = 1'b0;
    send_byte(8'hE0);
    send_byte(8'h6B);
    @(negedge CLK_50M);
    game_sel = 1'b1;
    #1;
    checks++;
    if (blk_key_press !== 5'b00001 || snk_key_press !== 4'b0) begin
      errors++;
      $display("FAIL sel_change: blk=%b snk=%b required blk=00001 snk=0000", blk_key_press, snk_key_press);
    end
  endtask

  task automatic test_invalid_no_gap;
    idle(20);
    game_sel = 1'b1;
    send_byte(8'h4D);
    send_byte(8'hE0);
    send_byte(8'h6B);
    @(negedge CLK_50M);
    checks++;
    if (snk_key_press !== 4'b0001 || blk_key_press !== 5'b0) begin
      errors++;
      $display("FAIL invalid_no_gap: blk=%b snk=%b required snk=0001", blk_key_press, snk_key_press);
    end
  endtask

  task automatic test_break;
    int cnt, sp;
    bit multi;
    idle(20);
    game_sel = 1'b0;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h72);
    watch(10, cnt, sp, multi);
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL ext_break: pulses=%0d required 0", cnt);
    end
    send_byte(8'hE0);
    send_byte(8'h72);
    @(negedge CLK_50M);
    checks++;
    if (blk_key_press !== 5'b00100) begin
      errors++;
      $display("FAIL down_after_break: blk=%b required 00100", blk_key_press);
    end
    idle(20);
    send_byte(8'hF0);
    send_byte(8'h2D);
    send_byte(8'h1C);
    watch(10, cnt, sp, multi);
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL break_unrecognised: pulses=%0d required 0", cnt);
    end
  endtask

  task automatic test_overflow;
    int cnt, sp;
    bit multi;
    do_reset();
    game_sel = 1'b0;
    fork
      repeat (6) send_byte(8'h2D);
      watch(150, cnt, sp, multi);
    join
    checks++;
    if (cnt !== 5 || sp !== 16 || multi) begin
      errors++;
      $display("FAIL overflow_pulses: count=%0d spacing=%0d multi=%0d required 5/16/0", cnt, sp, multi);
    end
    checks++;
    if (fifo_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: ovf=%b required 1", fifo_overflow);
    end
    idle(50);
    checks++;
    if (fifo_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf=%b required 1", fifo_overflow);
    end
  endtask

  task automatic test_back_to_back;
    int cnt, sp;
    bit multi;
    do_reset();
    game_sel = 1'b0;
    fork
      begin
        repeat (5) send_byte(8'h2D);
        idle(7);
        send_byte(8'h2D);
      end
      watch(150, cnt, sp, multi);
    join
    checks++;
    if (cnt !== 6 || sp !== 16 || multi) begin
      errors++;
      $display("FAIL full_push_pop_pulses: count=%0d spacing=%0d multi=%0d required 6/16/0", cnt, sp, multi);
    end
    checks++;
    if (fifo_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop_ovf: ovf=%b required 0", fifo_overflow);
    end
  endtask

  task automatic test_reset_mid;
    int cnt, sp;
    bit multi;
    do_reset();
    game_sel = 1'b0;
    repeat (4) send_byte(8'h2D);
    send_byte(8'hE0);
    RST_N = 1'b0;
    @(negedge CLK_50M);
    RST_N = 1'b1;
    checks++;
    if (blk_key_press !== 5'b0 || snk_key_press !== 4'b0 || fifo_overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: blk=%b snk=%b ovf=%b required 0", blk_key_press, snk_key_press, fifo_overflow);
    end
    watch(60, cnt, sp, multi);
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL mid_reset_queue: pulses=%0d required 0", cnt);
    end
    send_byte(8'h6B);
    watch(10, cnt, sp, multi);
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL mid_reset_prefix: pulses=%0d required 0", cnt);
    end
    send_byte(8'h2D);
    @(negedge CLK_50M);
    checks++;
    if (blk_key_press !== 5'b10000) begin
      errors++;
      $display("FAIL mid_reset_alive: blk=%b required 10000", blk_key_press);
    end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat;
    int cnt, sp;
    bit multi;
    do_reset();
    game_sel = 1'b0;
    fork
      begin
        send_byte(8'hE0);
        send_byte(8'h74);
        idle(140);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
      end
      watch(300, cnt, sp, multi);
    join
    checks++;
    if (cnt !== 4 || sp !== 20 || multi) begin
      errors++;
      $display("FAIL repeat_right: count=%0d spacing=%0d multi=%0d required 4/20/0", cnt, sp, multi);
    end
    send_byte(8'h4D);
    watch(300, cnt, sp, multi);
    checks++;
    if (cnt !== 1) begin
      errors++;
      $display("FAIL play_no_repeat: pulses=%0d required 1", cnt);
    end
  endtask
`else
  task automatic test_no_repeat;
    int cnt, sp;
    bit multi;
    do_reset();
    game_sel = 1'b0;
    fork
      begin
        send_byte(8'hE0);
        send_byte(8'h74);
      end
      watch(300, cnt, sp, multi);
    join
    checks++;
    if (cnt !== 1) begin
      errors++;
      $display("FAIL single_make: pulses=%0d required 1", cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mapping();
    test_sel_change();
    test_invalid_no_gap();
    test_break();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef KEY_REPEAT_EN
    test_repeat();
`else
    test_no_repeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_event_scheduler.md
KEY_EVENT_SCHEDULER -- requirements
Module: key_event_scheduler

Interface
REQ-001 Parameter DISPATCH_GAP, default 16: minimum number of cycles between two dispatched key pulses.
REQ-002 Parameter REPEAT_DELAY, default 25_000_000: cycles a key must be held before the first auto-repeat (0.5 s at 50 MHz).
REQ-003 Parameter REPEAT_RATE, default 5_000_000: cycles between successive auto-repeats.
REQ-004 CLK_50M  in  1  sole clock; all logic on its rising edge.
REQ-005 RST_N  in  1  reset; asynchronous, active-low.
REQ-006 ps2_byte  in  8  received PS/2 scan-code byte, valid when ps2_state is high.
REQ-007 ps2_state  in  1  one-cycle strobe marking a new ps2_byte.
REQ-008 game_sel  in  1  route target; 0 = block game, 1 = snake game; sampled at pop time only.
REQ-009 blk_key_press  out  5  one-cycle pulses to the block game {restart, play, down, right, left}.
REQ-010 snk_key_press  out  4  one-cycle pulses to the snake game {down, up, right, left}.
REQ-011 fifo_overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-012 Decoder FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0); the FSM advances only on ps2_state.
REQ-013 Transitions: IDLE-E0->EXT, IDLE-F0->BRK, EXT-F0->EXT_BRK; any other byte completes a code and returns the FSM to IDLE.
REQ-014 Recognised makes: E0 6B left, E0 74 right, E0 75 up, E0 72 down, 4D play, 2D restart; each completed make pushes a 3-bit event code into the FIFO.
REQ-015 Unrecognised make codes and all break codes push nothing.
REQ-016 FIFO: 4 entries, 3 bits wide; an event is visible at the head the cycle after its push.
REQ-017 Push while full with no pop: the event is dropped and fifo_overflow is set until reset.
REQ-018 Simultaneous push and pop while full: both are performed; no drop.
REQ-019 Dispatcher pops when the FIFO is non-empty and the gap counter is 0.
REQ-020 Routing: each pop is routed using game_sel as sampled in the pop cycle.
REQ-021 Pulse timing: the selected output bit is high exactly one cycle, in the cycle after the pop.
REQ-022 Pulse latency: with an empty FIFO and idle gap counter, the pulse occurs 2 cycles after the final make-byte strobe.
REQ-023 Gap counter: a pulse reloads the gap counter to DISPATCH_GAP-1; it decrements to 0 and saturates there.
REQ-024 Invalid-target events are popped with no pulse and no gap reload: up goes nowhere when routing to block; play or restart goes nowhere when routing to snake.
REQ-025 At most one bit across both output buses is high in any cycle.
REQ-026 A game_sel change does not affect an event already popped.

Reset
REQ-027 On RST_N low: blk_key_press=0, snk_key_press=0, fifo_overflow=0.
REQ-028 On RST_N low: FIFO empty, decoder in IDLE, gap counter 0, repeat timers 0.
REQ-029 Reset mid-operation discards queued events and any partial scan-code prefix; no pulse is emitted in the cycle after release.

Configuration
REQ-030 Macro KEY_REPEAT_EN compiles the auto-repeat feature in or out.
REQ-031 With KEY_REPEAT_EN defined, auto-repeat behaves as follows:
  - the last made arrow key is tracked as held;
  - after REPEAT_DELAY cycles held, its event is re-pushed every REPEAT_RATE cycles;
  - its break code, or a make of a different key, cancels the repeat;
  - play and restart never repeat.
REQ-032 Without KEY_REPEAT_EN, no held-key or timer logic exists and exactly one event is pushed per make.

Structure
REQ-033 Package key_sched_pkg holds: scan-code constants, the 3-bit event-code enum, the decoder state typedef, and the output bit-index constants.
REQ-034 The FIFO is a sub-module, key_event_fifo (push, pop, full, empty, data), instantiated once.

Verification
REQ-035 Stimulus E0 6B, game_sel=0 -> blk_key_press=5'b00001 for one cycle, 2 cycles after the 6B strobe.
REQ-036 Stimulus E0 75 with game_sel=1, then 4D with game_sel=1 -> snk_key_press=4'b0100 pulse; no pulse for 4D.
REQ-037 Stimulus: 6 makes of 2D in 6 consecutive strobes with game_sel=0 -> 4 or 5 restart pulses spaced ≥16 cycles apart; fifo_overflow=1 iff a drop occurred; it stays 1.
REQ-038 Stimulus E0 F0 72 (break only) -> no pulse; decoder back in IDLE; a following E0 72 gives a down pulse.
REQ-039 Stimulus: RST_N low for 1 cycle with 3 queued events -> no pulses afterward; all outputs 0.
REQ-040 With KEY_REPEAT_EN, REPEAT_DELAY=100, REPEAT_RATE=20: hold E0 74 for 160 cycles -> 1+3 right pulses; E0 F0 74 stops further repeats.
